// File: rtl/evn_ctl_mch.sv
// Multi-channel event controller: per-channel source select feeding an
// IDLE/PRE/ARM/POST sequencer with pre/post counters and trigger qualification.
module evn_ctl_mch #(
    parameter int unsigned CN = 2,
    parameter int unsigned EN = 2,
    parameter int unsigned CW = 32,
    parameter int unsigned SW = $clog2(EN + 1)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [CN-1:0][3:0]     evn_sw,
    input  logic [EN-1:0][3:0]     evn_ex,
    input  logic [CN-1:0][SW-1:0]  cfg_sel,
    input  logic [CN-1:0][CW-1:0]  cfg_pre,
    input  logic [CN-1:0][CW-1:0]  cfg_pst,
    input  logic [CN-1:0]          trg_i,
    input  logic [CN-1:0]          trg_msk,
    output logic [CN-1:0][3:0]     evn_o,
    output logic [CN-1:0]          ctl_run,
    output logic [CN-1:0]          ctl_arm,
    output logic [CN-1:0]          trg_o,
    output logic [CN-1:0]          sts_done,
    output logic [CN-1:0][CW-1:0]  sts_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        ARM,
        POST
    } state_e;

    state_e              state_q [CN];
    state_e              state_d [CN];
    logic [CN-1:0][3:0]  evn_sel;
    logic [CN-1:0][3:0]  evn_q;
    logic [CN-1:0][CW-1:0] cnt_q, cnt_d;
    logic [CN-1:0]       run_q, run_d;
    logic [CN-1:0]       arm_q, arm_d;
    logic [CN-1:0]       trg_q, trg_d;
    logic [CN-1:0]       done_q, done_d;

    // Out-of-range selects match no bus and leave the channel event-free.
    always_comb begin
        for (int unsigned ch = 0; ch < CN; ch++) begin
            evn_sel[ch] = '0;
            if (cfg_sel[ch] == '0) begin
                evn_sel[ch] = evn_sw[ch];
            end else begin
                for (int unsigned k = 0; k < EN; k++) begin
                    if (cfg_sel[ch] == SW'(k + 1)) evn_sel[ch] = evn_ex[k];
                end
            end
        end
    end

    always_comb begin
        for (int unsigned ch = 0; ch < CN; ch++) begin
            state_d[ch] = state_q[ch];
            cnt_d[ch]   = cnt_q[ch];
            trg_d[ch]   = 1'b0;
            done_d[ch]  = done_q[ch];

            if (evn_sel[ch][0]) begin
                state_d[ch] = IDLE;
                cnt_d[ch]   = '0;
                done_d[ch]  = 1'b0;
            end else if (evn_sel[ch][2]) begin
                state_d[ch] = IDLE;
                cnt_d[ch]   = '0;
            end else begin
                unique case (state_q[ch])
                    IDLE: begin
                        if (evn_sel[ch][1]) begin
                            state_d[ch] = PRE;
                            cnt_d[ch]   = '0;
                            done_d[ch]  = 1'b0;
                        end
                    end
                    PRE: begin
                        if (cnt_q[ch] >= cfg_pre[ch]) begin
                            state_d[ch] = ARM;
                            cnt_d[ch]   = '0;
                        end else begin
                            cnt_d[ch] = cnt_q[ch] + 1'b1;
                        end
                    end
                    ARM: begin
                        // A coincident (ignored) str outranks the trigger.
                        if (!evn_sel[ch][1] &&
                            (evn_sel[ch][3] || (trg_i[ch] && trg_msk[ch]))) begin
                            state_d[ch] = POST;
                            cnt_d[ch]   = '0;
                            trg_d[ch]   = 1'b1;
                        end
                    end
                    POST: begin
                        if (cnt_q[ch] >= cfg_pst[ch]) begin
                            state_d[ch] = IDLE;
                            cnt_d[ch]   = '0;
                            done_d[ch]  = 1'b1;
                        end else begin
                            cnt_d[ch] = cnt_q[ch] + 1'b1;
                        end
                    end
                    default: state_d[ch] = IDLE;
                endcase
            end

            run_d[ch] = (state_d[ch] != IDLE);
            arm_d[ch] = (state_d[ch] == ARM);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned ch = 0; ch < CN; ch++) state_q[ch] <= IDLE;
            evn_q  <= '0;
            cnt_q  <= '0;
            run_q  <= '0;
            arm_q  <= '0;
            trg_q  <= '0;
            done_q <= '0;
        end else begin
            for (int unsigned ch = 0; ch < CN; ch++) state_q[ch] <= state_d[ch];
            evn_q  <= evn_sel;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            arm_q  <= arm_d;
            trg_q  <= trg_d;
            done_q <= done_d;
        end
    end

    assign evn_o    = evn_q;
    assign ctl_run  = run_q;
    assign ctl_arm  = arm_q;
    assign trg_o    = trg_q;
    assign sts_done = done_q;
    assign sts_cnt  = cnt_q;

endmodule

// File: tb/tb_evn_ctl_mch.sv
// Directed self-checking bench for evn_ctl_mch (CN=2, EN=2, CW=32).
module tb_evn_ctl_mch;

    logic              clk = 1'b0;
    logic              rstn;
    logic [1:0][3:0]   evn_sw;
    logic [1:0][3:0]   evn_ex;
    logic [1:0][1:0]   cfg_sel;
    logic [1:0][31:0]  cfg_pre;
    logic [1:0][31:0]  cfg_pst;
    logic [1:0]        trg_i;
    logic [1:0]        trg_msk;
    logic [1:0][3:0]   evn_o;
    logic [1:0]        ctl_run;
    logic [1:0]        ctl_arm;
    logic [1:0]        trg_o;
    logic [1:0]        sts_done;
    logic [1:0][31:0]  sts_cnt;

    int n_chk = 0;
    int n_err = 0;

    evn_ctl_mch #(.CN(2), .EN(2), .CW(32)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .evn_sw   (evn_sw),
        .evn_ex   (evn_ex),
        .cfg_sel  (cfg_sel),
        .cfg_pre  (cfg_pre),
        .cfg_pst  (cfg_pst),
        .trg_i    (trg_i),
        .trg_msk  (trg_msk),
        .evn_o    (evn_o),
        .ctl_run  (ctl_run),
        .ctl_arm  (ctl_arm),
        .trg_o    (trg_o),
        .sts_done (sts_done),
        .sts_cnt  (sts_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive a one-cycle software event on ch0 and advance to the next cycle.
    task automatic sw0(input logic [3:0] ev);
        evn_sw[0] = ev;
        tick();
        evn_sw[0] = 4'b0000;
    endtask

    initial begin
        rstn    = 1'b0;
        evn_sw  = '0;
        evn_ex  = '0;
        cfg_sel = '0;
        cfg_pre = '0;
        cfg_pst = '0;
        trg_i   = '0;
        trg_msk = '0;
        tick(2);
        check("rst_run",  64'(ctl_run),  64'h0);
        check("rst_done", 64'(sts_done), 64'h0);
        check("rst_evn",  64'(evn_o),    64'h0);
        check("rst_cnt",  64'(sts_cnt),  64'h0);
        rstn = 1'b1;
        tick();

        // Basic sequence: str at t, pre=3, pst=2
        cfg_pre[0] = 32'd3;
        cfg_pst[0] = 32'd2;
        sw0(4'b0010);                                   // now t+1
        check("bas_run_t1",  64'(ctl_run[0]), 64'h1);
        check("bas_evn_t1",  64'(evn_o[0]),   64'h2);
        check("bas_ch1_idle",64'(ctl_run[1]), 64'h0);
        tick(3);                                        // t+4
        check("bas_arm_t4",  64'(ctl_arm[0]), 64'h0);
        check("bas_cnt_t4",  64'(sts_cnt[0]), 64'd3);
        tick();                                         // t+5
        check("bas_arm_t5",  64'(ctl_arm[0]), 64'h1);
        tick(2);                                        // t+7
        sw0(4'b1000);                                   // t+8
        check("bas_trg_t8",  64'(trg_o[0]),   64'h1);
        check("bas_arm_t8",  64'(ctl_arm[0]), 64'h0);
        tick();                                         // t+9
        check("bas_trg_t9",  64'(trg_o[0]),   64'h0);
        tick();                                         // t+10
        check("bas_run_t10", 64'(ctl_run[0]), 64'h1);
        tick();                                         // t+11
        check("bas_run_t11", 64'(ctl_run[0]), 64'h0);
        check("bas_done",    64'(sts_done[0]),64'h1);

        // Trigger filtering
        sw0(4'b0010);                                   // t+1 PRE
        check("flt_done_clr",64'(sts_done[0]),64'h0);
        trg_msk[0] = 1'b1;
        trg_i[0]   = 1'b1;
        tick();                                         // t+2
        trg_i[0]   = 1'b0;
        check("flt_pre_trg", 64'(trg_o[0]),   64'h0);
        tick(3);                                        // t+5 ARM
        check("flt_arm",     64'(ctl_arm[0]), 64'h1);
        trg_msk[0] = 1'b0;
        trg_i[0]   = 1'b1;
        tick();
        check("flt_msk_trg", 64'(trg_o[0]),   64'h0);
        check("flt_msk_arm", 64'(ctl_arm[0]), 64'h1);
        trg_msk[0] = 1'b1;
        tick();
        trg_i[0]   = 1'b0;
        check("flt_hw_trg",  64'(trg_o[0]),   64'h1);
        check("flt_hw_post", 64'({ctl_run[0], ctl_arm[0]}), 64'h2);
        tick(3);
        check("flt_end_run", 64'(ctl_run[0]), 64'h0);
        check("flt_end_done",64'(sts_done[0]),64'h1);

        // Simultaneous events
        sw0(4'b0110);
        check("sim_strstp_run", 64'(ctl_run[0]), 64'h0);
        check("sim_strstp_done",64'(sts_done[0]),64'h1);
        sw0(4'b0010);
        tick(4);                                        // ARM
        check("sim_arm",        64'(ctl_arm[0]), 64'h1);
        sw0(4'b1001);
        check("sim_rstswt_run", 64'(ctl_run[0]), 64'h0);
        check("sim_rstswt_done",64'(sts_done[0]),64'h0);
        check("sim_rstswt_trg", 64'(trg_o[0]),   64'h0);
        sw0(4'b0010);
        tick(4);
        sw0(4'b1000);                                   // POST
        check("sim_post_trg",   64'(trg_o[0]),   64'h1);
        sw0(4'b0100);
        check("sim_stp_run",    64'(ctl_run[0]), 64'h0);
        check("sim_stp_done",   64'(sts_done[0]),64'h0);
        check("sim_stp_trg",    64'(trg_o[0]),   64'h0);

        // Source select: both channels on evn_ex[1]
        cfg_sel[0] = 2'd2;
        cfg_sel[1] = 2'd2;
        evn_ex[1]  = 4'b0010;
        tick();
        evn_ex[1]  = 4'b0000;
        check("sel_run_both", 64'(ctl_run),  64'h3);
        check("sel_evn0",     64'(evn_o[0]), 64'h2);
        check("sel_evn1",     64'(evn_o[1]), 64'h2);
        evn_ex[1]  = 4'b0100;
        tick();
        evn_ex[1]  = 4'b0000;
        check("sel_stp_both", 64'(ctl_run),  64'h0);
        cfg_sel[0] = 2'd3;
        cfg_sel[1] = 2'd3;
        evn_ex     = {4'b0010, 4'b0010};
        evn_sw     = {4'b0010, 4'b0010};
        tick();
        evn_ex     = '0;
        evn_sw     = '0;
        check("sel3_run",     64'(ctl_run),  64'h0);
        check("sel3_evn",     64'(evn_o),    64'h0);
        cfg_sel    = '0;

        // Boundaries: zero-length PRE and POST
        cfg_pre[0] = 32'd0;
        cfg_pst[0] = 32'd0;
        sw0(4'b0010);
        check("b0_pre_run",  64'({ctl_run[0], ctl_arm[0]}), 64'h2);
        tick();
        check("b0_arm",      64'(ctl_arm[0]), 64'h1);
        sw0(4'b1000);
        check("b0_trg",      64'(trg_o[0]),   64'h1);
        tick();
        check("b0_post_end", 64'(ctl_run[0]), 64'h0);
        check("b0_done",     64'(sts_done[0]),64'h1);

        // Lower cfg_pst under the running count
        cfg_pst[0] = 32'd50;
        sw0(4'b0010);
        tick();
        sw0(4'b1000);                                   // POST cnt=0
        tick(10);
        check("low_cnt10",   64'(sts_cnt[0]), 64'd10);
        cfg_pst[0] = 32'd5;
        tick();
        check("low_run",     64'(ctl_run[0]), 64'h0);
        check("low_done",    64'(sts_done[0]),64'h1);

        // Asynchronous reset mid-POST
        cfg_pst[0] = 32'd100;
        sw0(4'b0010);
        tick();
        sw0(4'b1000);
        tick(40);
        check("ar_cnt40",    64'(sts_cnt[0]), 64'd40);
        check("ar_run_pre",  64'(ctl_run[0]), 64'h1);
        rstn = 1'b0;
        #1;
        check("ar_run",      64'(ctl_run),  64'h0);
        check("ar_cnt",      64'(sts_cnt),  64'h0);
        check("ar_evn",      64'(evn_o),    64'h0);
        check("ar_done",     64'(sts_done), 64'h0);
        check("ar_trg",      64'(trg_o),    64'h0);
        tick();
        rstn = 1'b1;
        tick(3);
        check("ar_idle_run", 64'(ctl_run),  64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
